// File: rtl/perf_counter_reader_pkg.sv
// Shared types for the performance-counter dump path: widths, header layout,
// dump FSM encodings and a helper that splits the counter bundle into words.
package perf_counter_reader_pkg;

  localparam int PERF_COUNTER_NUM = 10;
  localparam int DATA_PATH_WIDTH = 32;
  localparam logic [15:0] PERF_DUMP_HEADER_MAGIC = 16'hDB60;

  typedef logic [DATA_PATH_WIDTH-1:0] data_path_t;
  typedef logic [PERF_COUNTER_NUM*DATA_PATH_WIDTH-1:0] perf_counter_path_t;
  typedef data_path_t [PERF_COUNTER_NUM-1:0] perf_counter_words_t;

  typedef logic [1:0] perf_dump_state_t;
  localparam perf_dump_state_t ST_IDLE   = 2'd0;
  localparam perf_dump_state_t ST_HEADER = 2'd1;
  localparam perf_dump_state_t ST_BODY   = 2'd2;

  typedef struct packed {
    logic [15:0] magic;
    logic [7:0]  seq;
    logic [7:0]  count;
  } perf_dump_header_t;

  // Word 0 is the first-declared counter, which sits in the MSB slice.
  function automatic perf_counter_words_t flatten_perf_counters(input perf_counter_path_t path);
    perf_counter_words_t words;
    for (int i = 0; i < PERF_COUNTER_NUM; i++)
      words[i] = path[(PERF_COUNTER_NUM-1-i)*DATA_PATH_WIDTH +: DATA_PATH_WIDTH];
    return words;
  endfunction

endpackage

// File: rtl/perf_counter_reader_snapshot_reg.sv
// Shadow copy of the counter bundle, captured on load, with a word-select mux.
module perf_counter_reader_snapshot_reg
  import perf_counter_reader_pkg::*;
#(
  parameter int COUNTER_NUM = PERF_COUNTER_NUM,
  parameter int WORD_WIDTH  = DATA_PATH_WIDTH,
  parameter int IDX_W       = 4
) (
  input  logic                              clk,
  input  logic                              rstN,
  input  logic                              load,
  input  logic [COUNTER_NUM*WORD_WIDTH-1:0] perfCounter,
  input  logic [IDX_W-1:0]                  idx,
  output logic [WORD_WIDTH-1:0]             word
);

  logic [WORD_WIDTH-1:0] shadow [COUNTER_NUM];

  // Stored in dump order so the index selects directly.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < COUNTER_NUM; i++) shadow[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < COUNTER_NUM; i++)
        shadow[i] <= perfCounter[(COUNTER_NUM-1-i)*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  assign word = shadow[idx];

endmodule

// File: rtl/perf_counter_reader.sv
// Snapshots the core's performance counters on request and streams them out
// as a header word plus one word per counter over a valid/ready interface.
//
// state  | meaning
// IDLE   | waiting for snapshotReq; shadow register follows nothing
// HEADER | presenting {magic, seq, count}
// BODY   | presenting shadow word[idx]; last word carries outLast
module perf_counter_reader
  import perf_counter_reader_pkg::*;
#(
  parameter int          COUNTER_NUM  = PERF_COUNTER_NUM,
  parameter int          WORD_WIDTH   = DATA_PATH_WIDTH,
  parameter logic [15:0] HEADER_MAGIC = PERF_DUMP_HEADER_MAGIC
) (
  input  logic                              clk,
  input  logic                              rstN,
  input  logic [COUNTER_NUM*WORD_WIDTH-1:0] perfCounter,
  input  logic                              snapshotReq,
  output logic                              outValid,
  input  logic                              outReady,
  output logic [WORD_WIDTH-1:0]             outData,
  output logic                              outLast,
  output logic                              busy,
  output logic                              overrun,
  output logic [7:0]                        seqNum
);

  localparam int IDX_W = (COUNTER_NUM > 1) ? $clog2(COUNTER_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNTER_NUM - 1);

  perf_dump_state_t  state;
  logic [IDX_W-1:0]  idx;
  logic [WORD_WIDTH-1:0] sel_word;
  perf_dump_header_t hdr;
  logic              load;

  assign load = (state == ST_IDLE) && snapshotReq;

  perf_counter_reader_snapshot_reg #(
    .COUNTER_NUM(COUNTER_NUM),
    .WORD_WIDTH (WORD_WIDTH),
    .IDX_W      (IDX_W)
  ) u_snapshot (
    .clk        (clk),
    .rstN       (rstN),
    .load       (load),
    .perfCounter(perfCounter),
    .idx        (idx),
    .word       (sel_word)
  );

  // Requests arriving outside IDLE, including on the final handshake, are dropped.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= ST_IDLE;
      idx     <= '0;
      seqNum  <= 8'd0;
      overrun <= 1'b0;
    end else begin
      if (snapshotReq && (state != ST_IDLE)) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (snapshotReq) state <= ST_HEADER;
        end
        ST_HEADER: begin
          if (outReady) begin
            seqNum <= seqNum + 8'd1;
            idx    <= '0;
            state  <= ST_BODY;
          end
        end
        ST_BODY: begin
          if (outReady) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= ST_IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign hdr.magic = HEADER_MAGIC;
  assign hdr.seq   = seqNum;
  assign hdr.count = 8'(COUNTER_NUM);

  // Outputs decode from registered state only, so they stay put across stalls.
  always_comb begin
    outData = '0;
    case (state)
      ST_HEADER: outData = WORD_WIDTH'(hdr);
      ST_BODY:   outData = sel_word;
      default:   outData = '0;
    endcase
  end

  assign busy     = (state != ST_IDLE);
  assign outValid = busy;
  assign outLast  = (state == ST_BODY) && (idx == LAST_IDX);

endmodule

// File: tb/tb_perf_counter_reader.sv
// Directed bench for perf_counter_reader: dump contents, stalls, snapshot
// isolation, overrun, sequence wrap and asynchronous reset mid-dump.
module tb_perf_counter_reader;

  logic         clk = 1'b0;
  logic         rstN = 1'b1;
  logic [319:0] perfCounter = '0;
  logic         snapshotReq = 1'b0;
  logic         outValid;
  logic         outReady = 1'b0;
  logic [31:0]  outData;
  logic         outLast;
  logic         busy;
  logic         overrun;
  logic [7:0]   seqNum;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_val [10];
  logic [31:0] got_data [16];
  logic        got_last [16];
  int          n_got;
  int          busy_cyc;

  perf_counter_reader dut (
    .clk        (clk),
    .rstN       (rstN),
    .perfCounter(perfCounter),
    .snapshotReq(snapshotReq),
    .outValid   (outValid),
    .outReady   (outReady),
    .outData    (outData),
    .outLast    (outLast),
    .busy       (busy),
    .overrun    (overrun),
    .seqNum     (seqNum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_counters(input logic [31:0] base);
    for (int i = 0; i < 10; i++) begin
      exp_val[i] = base + 32'(i) + 32'd1;
      perfCounter[(9-i)*32 +: 32] = exp_val[i];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstN = 1'b0;
    snapshotReq = 1'b0;
    outReady = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic req_pulse();
    @(negedge clk);
    snapshotReq = 1'b1;
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1.
  // inj_k >= 0 re-requests on handshake number inj_k and on the final handshake.
  task automatic collect(input int mode, input bit scramble, input int inj_k);
    bit done = 1'b0;
    int cyc = 0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [31:0] pd = '0;
    n_got = 0;
    busy_cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      snapshotReq = 1'b0;
      if (scramble)
        for (int i = 0; i < 10; i++) perfCounter[i*32 +: 32] = $urandom;
      if (busy) busy_cyc++;
      if (pv && !pr) begin
        chk("stall_valid", 32'(outValid), 32'd1);
        chk("stall_data", outData, pd);
        chk("stall_last", 32'(outLast), 32'(pl));
      end
      outReady = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (outValid && outReady) begin
        if (n_got < 16) begin
          got_data[n_got] = outData;
          got_last[n_got] = outLast;
        end
        if (inj_k >= 0 && (n_got == inj_k || outLast)) snapshotReq = 1'b1;
        n_got++;
        if (outLast) done = 1'b1;
      end
      pv = outValid; pr = outReady; pd = outData; pl = outLast;
      cyc++;
    end
    chk("dump_done", 32'(done), 32'd1);
    @(negedge clk);
    snapshotReq = 1'b0;
    outReady = 1'b0;
  endtask

  task automatic verify(input logic [7:0] seq);
    chk("n_words", 32'(n_got), 32'd11);
    chk("header", got_data[0], {16'hDB60, seq, 8'h0A});
    for (int i = 1; i <= 10; i++)
      chk($sformatf("word%0d", i), got_data[i], exp_val[i-1]);
    for (int i = 0; i <= 10; i++)
      chk($sformatf("last%0d", i), 32'(got_last[i]), (i == 10) ? 32'd1 : 32'd0);
  endtask

  initial begin
    // reset values
    #3 rstN = 1'b0;
    #1;
    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_data", outData, 32'd0);
    chk("rst_last", 32'(outLast), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_seq", 32'(seqNum), 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    // basic dump, counters 1..10
    load_counters(32'd0);
    req_pulse();
    collect(0, 1'b0, -1);
    verify(8'd0);
    chk("busy_cycles", 32'(busy_cyc), 32'd11);
    chk("busy_after", 32'(busy), 32'd0);
    chk("seq_after", 32'(seqNum), 32'd1);

    // stalled sink
    load_counters(32'd0);
    req_pulse();
    collect(1, 1'b0, -1);
    verify(8'd1);

    // counters move during the dump
    load_counters(32'h1000);
    req_pulse();
    collect(0, 1'b1, -1);
    verify(8'd2);
    chk("overrun_clean", 32'(overrun), 32'd0);

    // requests while busy, including on the final handshake
    do_reset();
    load_counters(32'd100);
    req_pulse();
    collect(0, 1'b0, 3);
    verify(8'd0);
    repeat (3) @(negedge clk);
    chk("ovr_no_redump", 32'(busy), 32'd0);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_seq", 32'(seqNum), 32'd1);
    load_counters(32'd200);
    req_pulse();
    collect(0, 1'b0, -1);
    verify(8'd1);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // asynchronous reset at body index 4
    load_counters(32'd0);
    @(negedge clk);
    snapshotReq = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    snapshotReq = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_word", outData, 32'd5);
    #2 rstN = 1'b0;
    #1;
    chk("arst_valid", 32'(outValid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_last", 32'(outLast), 32'd0);
    chk("arst_seq", 32'(seqNum), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    outReady = 1'b0;
    load_counters(32'd50);
    req_pulse();
    collect(0, 1'b0, -1);
    verify(8'd0);

    // sequence number wrap
    do_reset();
    load_counters(32'd7);
    for (int k = 0; k < 256; k++) begin
      req_pulse();
      collect(0, 1'b0, -1);
      chk($sformatf("wrap_hdr%0d", k), got_data[0], {16'hDB60, 8'(k), 8'h0A});
    end
    chk("wrap_seq", 32'(seqNum), 32'd0);
    req_pulse();
    collect(0, 1'b0, -1);
    verify(8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
